// File: rtl/sl_pkg.sv
// Shared definitions for the two-wire serial-link transceiver:
// status bit positions, state encodings and configuration decoding helpers.
package sl_pkg;

    localparam int unsigned ST_RX_VALID    = 0;
    localparam int unsigned ST_PARITY_ERR  = 1;
    localparam int unsigned ST_COUNT_ERR   = 2;
    localparam int unsigned ST_WIDTH_ERR   = 3;
    localparam int unsigned ST_TIMEOUT_ERR = 4;
    localparam int unsigned ST_TX_BUSY     = 5;

    typedef enum logic [1:0] {
        RX_IDLE       = 2'd0,
        RX_BIT        = 2'd1,
        RX_STOP_CHECK = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LOW  = 2'd1,
        TX_HIGH = 2'd2
    } tx_state_t;

    // Half-symbol time: 00 -> base, 01 -> base/2, 10 -> 2*base, 11 -> 4*base.
    function automatic logic [15:0] rate_to_t(input logic [1:0] rate, input int unsigned base_t);
        logic [15:0] b;
        b = 16'(base_t);
        case (rate)
            2'b00:   rate_to_t = b;
            2'b01:   rate_to_t = b >> 1;
            2'b10:   rate_to_t = b << 1;
            default: rate_to_t = b << 2;
        endcase
    endfunction

    function automatic logic [5:0] legal_wlen(input logic [5:0] code, input int unsigned def_wlen);
        if (code >= 6'd8 && code <= 6'd32) legal_wlen = code;
        else                               legal_wlen = 6'(def_wlen);
    endfunction

endpackage

// File: rtl/sl_rx.sv
// Serial-link receiver: synchronises the two lines, measures each low interval
// and assembles bits, parity and stop into a checked word.
module sl_rx
    import sl_pkg::*;
#(
    parameter int unsigned DEF_WLEN = 16,
    parameter int unsigned BASE_T   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line0,
    input  logic        line1,
    input  logic [7:0]  cfg,
    output logic [31:0] data,
    output logic        rx_valid,
    output logic        parity_err,
    output logic        count_err,
    output logic        width_err,
    output logic        timeout_err
);

    rx_state_t   state;
    logic [1:0]  meta, sync;
    logic        low_prev, seen0, seen1;
    logic [15:0] width, gap, t_q;
    logic [5:0]  count, wlen_q;
    logic [32:0] shreg;

    logic        low_now, fall, rise, reach_long, pulse_ok, pulse_bad;
    logic        is_stop, timeout, parity_odd, count_ok;
    logic [15:0] t_cur, two_t;
    logic [31:0] data_mask;
    logic [32:0] frame_mask;

    // A low interval is the union of both lines being low; overlap means stop.
    always_comb begin
        t_cur      = (state == RX_IDLE) ? rate_to_t(cfg[7:6], BASE_T) : t_q;
        two_t      = t_cur << 1;
        low_now    = ~sync[0] | ~sync[1];
        fall       = low_now & ~low_prev;
        rise       = ~low_now & low_prev;
        reach_long = low_now & low_prev & (width == two_t - 16'd1);
        pulse_ok   = rise & (width >= (t_cur >> 1)) & (width < two_t);
        pulse_bad  = rise & (width > (t_cur >> 3)) & (width < (t_cur >> 1));
        is_stop    = seen0 & seen1;
        timeout    = (state == RX_BIT) & (gap >= (t_cur << 3));
        data_mask  = 32'((33'd1 << wlen_q) - 33'd1);
        frame_mask = (33'd1 << (wlen_q + 6'd1)) - 33'd1;
        parity_odd = ^(shreg & frame_mask);
        count_ok   = (count == wlen_q + 6'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta        <= 2'b11;
            sync        <= 2'b11;
            low_prev    <= 1'b0;
            seen0       <= 1'b0;
            seen1       <= 1'b0;
            width       <= '0;
            gap         <= '0;
            t_q         <= '0;
            count       <= '0;
            wlen_q      <= '0;
            shreg       <= '0;
            data        <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            count_err   <= 1'b0;
            width_err   <= 1'b0;
            timeout_err <= 1'b0;
            state       <= RX_IDLE;
        end else begin
            meta     <= {line1, line0};
            sync     <= meta;
            low_prev <= low_now;

            if (fall) begin
                width <= 16'd1;
                seen0 <= ~sync[0];
                seen1 <= ~sync[1];
            end else if (low_now) begin
                if (width != '1) width <= width + 16'd1;
                seen0 <= seen0 | ~sync[0];
                seen1 <= seen1 | ~sync[1];
            end

            if (fall)           gap <= '0;
            else if (gap != '1) gap <= gap + 16'd1;

            case (state)
                RX_IDLE: begin
                    if (reach_long || pulse_bad) begin
                        width_err <= 1'b1;
                        rx_valid  <= 1'b0;
                    end else if (pulse_ok) begin
                        rx_valid    <= 1'b0;
                        parity_err  <= 1'b0;
                        count_err   <= 1'b0;
                        width_err   <= 1'b0;
                        timeout_err <= 1'b0;
                        t_q         <= t_cur;
                        wlen_q      <= legal_wlen(cfg[5:0], DEF_WLEN);
                        if (is_stop) begin
                            shreg <= '0;
                            count <= '0;
                            state <= RX_STOP_CHECK;
                        end else begin
                            shreg <= {32'd0, seen1};
                            count <= 6'd1;
                            state <= RX_BIT;
                        end
                    end
                end
                RX_BIT: begin
                    if (reach_long || pulse_bad) begin
                        width_err <= 1'b1;
                        rx_valid  <= 1'b0;
                        state     <= RX_IDLE;
                    end else if (pulse_ok) begin
                        if (is_stop) begin
                            state <= RX_STOP_CHECK;
                        end else begin
                            if (count <= 6'd32) shreg <= shreg | ({32'd0, seen1} << count);
                            if (count != '1) count <= count + 6'd1;
                        end
                    end else if (timeout) begin
                        timeout_err <= 1'b1;
                        rx_valid    <= 1'b0;
                        state       <= RX_IDLE;
                    end
                end
                RX_STOP_CHECK: begin
                    count_err  <= ~count_ok;
                    parity_err <= ~parity_odd;
                    rx_valid   <= count_ok & parity_odd;
                    data       <= shreg[31:0] & data_mask;
                    state      <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sl_tx.sv
// Serial-link transmitter: sends data bits LSB first, then odd parity, then
// the stop symbol, each as a T-long low phase followed by a T-long high phase.
module sl_tx
    import sl_pkg::*;
#(
    parameter int unsigned DEF_WLEN = 16,
    parameter int unsigned BASE_T   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  cfg,
    input  logic [31:0] data,
    input  logic        start,
    output logic        line0,
    output logic        line1,
    output logic        busy
);

    tx_state_t   state;
    logic        start_prev, parity_q;
    logic [31:0] data_q;
    logic [15:0] t_q, phase;
    logic [5:0]  wlen_q, idx;

    logic [5:0]  wlen_new;
    logic [31:0] data_new;
    logic        sym_bit, sym_stop, drive_low, phase_end;

    always_comb begin
        wlen_new  = legal_wlen(cfg[5:0], DEF_WLEN);
        data_new  = data & 32'((33'd1 << wlen_new) - 33'd1);
        sym_stop  = (idx == wlen_q + 6'd1);
        sym_bit   = (idx == wlen_q) ? parity_q : data_q[idx[4:0]];
        drive_low = (state == TX_LOW);
        phase_end = (phase == t_q - 16'd1);
        line0     = ~(drive_low & (sym_stop | ~sym_bit));
        line1     = ~(drive_low & (sym_stop | sym_bit));
        busy      = (state != TX_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_prev <= 1'b0;
            parity_q   <= 1'b0;
            data_q     <= '0;
            t_q        <= '0;
            phase      <= '0;
            wlen_q     <= '0;
            idx        <= '0;
            state      <= TX_IDLE;
        end else begin
            start_prev <= start;
            case (state)
                TX_IDLE: begin
                    if (start && !start_prev) begin
                        data_q   <= data_new;
                        parity_q <= ~^data_new;
                        wlen_q   <= wlen_new;
                        t_q      <= rate_to_t(cfg[7:6], BASE_T);
                        idx      <= '0;
                        phase    <= '0;
                        state    <= TX_LOW;
                    end
                end
                TX_LOW: begin
                    if (phase_end) begin
                        phase <= '0;
                        state <= TX_HIGH;
                    end else begin
                        phase <= phase + 16'd1;
                    end
                end
                TX_HIGH: begin
                    if (phase_end) begin
                        phase <= '0;
                        if (sym_stop) begin
                            state <= TX_IDLE;
                        end else begin
                            idx   <= idx + 6'd1;
                            state <= TX_LOW;
                        end
                    end else begin
                        phase <= phase + 16'd1;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sl_transceiver.sv
// Two-wire serial-link transceiver top: independent receiver and transmitter
// sharing clock, reset and configuration, with a packed status word.
module sl_transceiver
    import sl_pkg::*;
#(
    parameter int unsigned DEF_WLEN = 16,
    parameter int unsigned BASE_T   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sl0_i,
    input  logic        sl1_i,
    output logic        sl0_o,
    output logic        sl1_o,
    // 'config' is a reserved word, so the configuration port is cfg.
    input  logic [15:0] cfg,
    output logic [31:0] rx_data,
    output logic [15:0] status,
    input  logic [31:0] tx_data,
    input  logic        send_now
);

    logic rx_valid, parity_err, count_err, width_err, timeout_err, tx_busy;
    logic unused_cfg;

    assign unused_cfg = ^cfg[15:8];

    sl_rx #(
        .DEF_WLEN(DEF_WLEN),
        .BASE_T  (BASE_T)
    ) u_rx (
        .clk        (clk),
        .rst_n      (reset),
        .line0      (sl0_i),
        .line1      (sl1_i),
        .cfg        (cfg[7:0]),
        .data       (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .count_err  (count_err),
        .width_err  (width_err),
        .timeout_err(timeout_err)
    );

    sl_tx #(
        .DEF_WLEN(DEF_WLEN),
        .BASE_T  (BASE_T)
    ) u_tx (
        .clk  (clk),
        .rst_n(reset),
        .cfg  (cfg[7:0]),
        .data (tx_data),
        .start(send_now),
        .line0(sl0_o),
        .line1(sl1_o),
        .busy (tx_busy)
    );

    always_comb begin
        status                 = '0;
        status[ST_RX_VALID]    = rx_valid;
        status[ST_PARITY_ERR]  = parity_err;
        status[ST_COUNT_ERR]   = count_err;
        status[ST_WIDTH_ERR]   = width_err;
        status[ST_TIMEOUT_ERR] = timeout_err;
        status[ST_TX_BUSY]     = tx_busy;
    end

endmodule

// File: tb/tb_sl_transceiver.sv
// Directed bench for sl_transceiver: loopback frames at several lengths and
// rates, plus hand-driven receive frames exercising each error flag.
`timescale 1ns/1ps
module tb_sl_transceiver;

    logic        clk = 1'b0;
    logic        reset;
    logic        sl0_i, sl1_i, sl0_o, sl1_o;
    logic [15:0] cfg;
    logic [31:0] rx_data;
    logic [15:0] status;
    logic [31:0] tx_data;
    logic        send_now;
    logic        loop, drv0, drv1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign sl0_i = loop ? sl0_o : drv0;
    assign sl1_i = loop ? sl1_o : drv1;

    sl_transceiver #(
        .DEF_WLEN(16),
        .BASE_T  (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sl0_i   (sl0_i),
        .sl1_i   (sl1_i),
        .sl0_o   (sl0_o),
        .sl1_o   (sl1_o),
        .cfg     (cfg),
        .rx_data (rx_data),
        .status  (status),
        .tx_data (tx_data),
        .send_now(send_now)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // kind: 0 = sl0 pulse, 1 = sl1 pulse, 2 = stop; gw > 0 adds an sl0 pulse mid-gap
    task automatic drive_sym(input int kind, input int t, input int gw);
        drv0 = !(kind == 0 || kind == 2);
        drv1 = !(kind == 1 || kind == 2);
        tick(t);
        drv0 = 1'b1;
        drv1 = 1'b1;
        if (gw == 0) begin
            tick(t);
        end else begin
            tick(t / 2);
            drv0 = 1'b0;
            tick(gw);
            drv0 = 1'b1;
            tick(t - t / 2 - gw);
        end
    endtask

    task automatic run_tx(input logic [15:0] c, input logic [31:0] d, input int par_idx,
                          input bit hold, output int busy_cnt, output int syms,
                          output logic [1:0] par_line);
        logic low, prev_low;
        busy_cnt = 0;
        syms     = 0;
        par_line = 2'b00;
        prev_low = 1'b0;
        cfg      = c;
        tx_data  = d;
        send_now = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick(1);
            if (!hold && i == 9) send_now = 1'b0;
            if (status[5]) busy_cnt++;
            low = ~sl0_o | ~sl1_o;
            if (low && !prev_low) begin
                syms++;
                if (syms == par_idx + 1) par_line = {~sl1_o, ~sl0_o};
            end
            prev_low = low;
            if (!status[5]) break;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          busy_cnt, syms;
        logic [1:0]  par_line;
        logic [31:0] w;

        reset = 1'b0; loop = 1'b0; drv0 = 1'b1; drv1 = 1'b1;
        cfg = '0; tx_data = '0; send_now = 1'b0;
        tick(3);
        check("rst_sl0", 32'(sl0_o), 1);
        check("rst_sl1", 32'(sl1_o), 1);
        check("rst_rx_data", rx_data, 0);
        check("rst_status", 32'(status), 0);
        reset = 1'b1;
        tick(5);

        // Loopback, wlen 16, T 16
        loop = 1'b1;
        run_tx(16'h0000, 32'h0000_E3F1, 16, 1'b0, busy_cnt, syms, par_line);
        check("lb16_busy_cycles", busy_cnt, 576);
        check("lb16_symbols", syms, 18);
        check("lb16_parity_line", 32'(par_line), 32'h2);
        tick(4);
        check("lb16_rx_data", rx_data, 32'h0000_E3F1);
        check("lb16_status", 32'(status), 32'h1);

        // Loopback, wlen 8, send_now held high throughout
        tick(5);
        run_tx(16'h0008, 32'hFFFF_FFA5, 8, 1'b1, busy_cnt, syms, par_line);
        check("lb8_busy_cycles", busy_cnt, 320);
        check("lb8_symbols", syms, 10);
        check("lb8_parity_line", 32'(par_line), 32'h2);
        tick(20);
        check("lb8_no_retransmit", 32'(status[5]), 0);
        check("lb8_rx_data", rx_data, 32'h0000_00A5);
        check("lb8_status", 32'(status), 32'h1);
        send_now = 1'b0;

        // Loopback, rate 01 (T 8), wlen 32
        tick(5);
        run_tx(16'h0060, 32'h8000_0001, 32, 1'b0, busy_cnt, syms, par_line);
        check("lb32_busy_cycles", busy_cnt, 544);
        check("lb32_symbols", syms, 34);
        tick(4);
        check("lb32_rx_data", rx_data, 32'h8000_0001);
        check("lb32_status", 32'(status), 32'h1);

        // Directed receive: parity symbol on the wrong line
        loop = 1'b0; cfg = 16'h0000; tick(5);
        w = 32'h0000_E3F1;
        for (int i = 0; i < 16; i++) drive_sym(int'(w[i]), 16, 0);
        drive_sym(0, 16, 0);
        drive_sym(2, 16, 0);
        tick(4);
        check("par_err_flag", 32'(status[1]), 1);
        check("par_err_valid", 32'(status[0]), 0);

        // 1-clk glitch in a gap is ignored
        for (int i = 0; i < 16; i++) drive_sym(int'(w[i]), 16, (i == 3) ? 1 : 0);
        drive_sym(1, 16, 0);
        drive_sym(2, 16, 0);
        tick(4);
        check("glitch1_rx_data", rx_data, 32'h0000_E3F1);
        check("glitch1_status", 32'(status), 32'h1);

        // 4-clk pulse in a gap is a width error
        for (int i = 0; i < 4; i++) drive_sym(int'(w[i]), 16, (i == 3) ? 4 : 0);
        tick(8);
        check("glitch4_width_err", 32'(status[3]), 1);
        check("glitch4_valid", 32'(status[0]), 0);
        tick(20);

        // Stop after 5 data bits
        drive_sym(1, 16, 0); drive_sym(0, 16, 0); drive_sym(1, 16, 0);
        drive_sym(1, 16, 0); drive_sym(0, 16, 0); drive_sym(2, 16, 0);
        tick(4);
        check("short_count_err", 32'(status[2]), 1);
        check("short_valid", 32'(status[0]), 0);

        // Line held low 40 clk mid-word
        drive_sym(0, 16, 0); drive_sym(1, 16, 0);
        drv0 = 1'b0; tick(40); drv0 = 1'b1; tick(10);
        check("long_width_err", 32'(status[3]), 1);
        tick(10);

        // No falling edge for 8T while in a word
        drive_sym(1, 16, 0); drive_sym(1, 16, 0); drive_sym(0, 16, 0);
        tick(80);
        check("timeout_not_early", 32'(status[4]), 0);
        tick(40);
        check("timeout_err", 32'(status[4]), 1);

        // Reset in the middle of a transmission
        cfg = 16'h0000; tx_data = 32'h0000_E3F1; send_now = 1'b1;
        tick(1);
        send_now = 1'b0;
        tick(4);
        check("midtx_sl1_low", 32'(sl1_o), 0);
        check("midtx_busy", 32'(status[5]), 1);
        reset = 1'b0;
        #1;
        check("midtx_rst_sl0", 32'(sl0_o), 1);
        check("midtx_rst_sl1", 32'(sl1_o), 1);
        check("midtx_rst_busy", 32'(status[5]), 0);
        check("midtx_rst_status", 32'(status), 0);
        check("midtx_rst_rx_data", rx_data, 0);
        tick(3);
        reset = 1'b1;
        tick(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
